amstrad_ram_arbiter: RTL and testbench
======================================

// Module: amstrad_ram_arbiter
// PURPOSE
// - Sits directly downstream of the MMU: takes the MMU's 23-bit physical address (ram_A) for CPU cycles
//   and arbitrates it against gate-array video fetches onto one single-port SDRAM request/ack channel.
// - Video reads always target base 64KB RAM; CPU writes are posted into a one-entry write buffer.
// - Produces CPU read data, CPU wait, and 16-bit video words.
// PARAMETERS
// - VID_BASE   7'h02  value of mem_addr[22:16] for video fetches (base 64KB page group)
// - MAX_WAIT   8'd64  cycles without mem_ack before an access is abandoned (err_timeout pulse)
// PORTS
// - CLK          in   1   system clock; all logic on posedge
// - reset        in   1   synchronous, active-high
// - cpu_rd       in   1   CPU memory read level; rising edge starts a read
// - cpu_wr       in   1   CPU memory write level; rising edge posts a write
// - cpu_addr     in   23  physical address from MMU (ram_A)
// - cpu_dout     in   8   CPU write data
// - cpu_din      out  8   CPU read data, held until next read completes
// - cpu_wait     out  1   stall CPU (read in flight, or write with buffer full)
// - vid_req      in   1   one-cycle pulse: fetch one 16-bit word
// - vid_addr     in   15  word address within base 64KB
// - vid_data     out  16  {high byte, low byte} of fetched word
// - vid_valid    out  1   one-cycle pulse when vid_data updated
// - mem_req      out  1   request to SDRAM ctrl; held high until mem_ack
// - mem_we       out  1   1 = write; stable while mem_req high
// - mem_addr     out  23  byte address; stable while mem_req high
// - mem_wdata    out  8   write byte; stable while mem_req high
// - mem_rdata    in   8   read byte, valid in the mem_ack cycle
// - mem_ack      in   1   one-cycle completion pulse
// - err_timeout  out  1   one-cycle pulse on MAX_WAIT expiry
// BEHAVIOUR
// - Reset: state IDLE; mem_req/mem_we/cpu_wait/vid_valid/err_timeout=0; cpu_din=8'hFF; vid_data=0;
//   mem_addr/mem_wdata=0; write buffer empty; pending video/read flags cleared. Reset mid-access drops mem_req
//   in the next cycle; a mem_ack arriving in IDLE is ignored.
// - Edge detect: old_rd/old_wr registers; start on ~old & new. Stimulus must hold cpu_addr stable from edge to cpu_wait low.
// - Write post: rising cpu_wr with buffer empty -> capture {addr,data}, no wait. Buffer full -> cpu_wait=1 next cycle
//   until buffer drains, then capture and release wait in the same cycle.
// - Read: rising cpu_rd -> cpu_wait=1 next cycle. If buffer valid and addr matches, cpu_din=buffered data, wait
//   released the following cycle, no mem access. Otherwise read queued; buffer drains first (ordering).
// - vid_req latched into a pending flag; a second vid_req while pending is dropped (not queued).
// - FSM states: IDLE, VID_LO, VID_HI, CPU_WR, CPU_RD.
//   IDLE priority: video pending > write buffer > CPU read. Grant drives mem_req=1 the next cycle.
//   VID_LO: addr={VID_BASE,vid_addr,1'b0}; on ack store low byte -> VID_HI (no IDLE gap).
//   VID_HI: addr LSB=1; on ack vid_data={rdata,low}, vid_valid=1 -> IDLE.
//   CPU_WR: on ack clear buffer -> IDLE. CPU_RD: on ack cpu_din=mem_rdata, cpu_wait=0 -> IDLE.
// - mem_req falls the cycle after mem_ack; min one IDLE cycle between accesses except VID_LO->VID_HI.
// - Timeout: 8-bit counter resets on each grant; reaching MAX_WAIT -> mem_req=0, err_timeout=1, state IDLE;
//   aborted read returns 8'hFF and releases wait; aborted write clears buffer; aborted video gives no vid_valid.
// - Simultaneous vid_req and CPU edge in one cycle: both latched; video served first.
// - vid_addr wraps within 64KB; cpu_addr passed through unchanged (ROM pages included).
// STRUCTURE
// - Shared package: FSM state enum, VID_BASE default, 8'hFF open-bus constant.
// - One sub-module: amstrad_wr_buffer (single-entry addr/data register, valid flag, address-match compare).
// TESTING
// - Post write A=23'h020100 D=8'h5A, ack after 3 cycles -> no cpu_wait, mem_we=1, mem_addr/wdata match, buffer empties.
// - Read same address before drain -> cpu_din=8'h5A from buffer, no read access issued.
// - vid_req vid_addr=15'h0010 with CPU read pending -> accesses 23'h020020, 23'h020021, then CPU read;
//   vid_data={byte@21,byte@20}, single vid_valid pulse.
// - Two back-to-back writes, ack delayed 10 cycles -> second write stalls with cpu_wait until first acks.
// - Withhold mem_ack 64 cycles on read -> err_timeout pulse, cpu_din=8'hFF, cpu_wait=0, FSM IDLE.
// - Assert reset during VID_HI -> mem_req low next cycle, vid_valid never fires, later ack ignored.

Source files
------------

// File: rtl/amstrad_ram_arbiter_pkg.sv
// Shared types and constants for the Amstrad RAM arbiter.
// Covers the arbiter FSM states, the default video page group and the open-bus value.
package amstrad_ram_arbiter_pkg;

    localparam int ADDR_W = 23;

    localparam logic [6:0] VID_BASE_DEFAULT = 7'h02;
    localparam logic [7:0] MAX_WAIT_DEFAULT = 8'd64;
    localparam logic [7:0] OPEN_BUS         = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        VID_LO,
        VID_HI,
        CPU_WR,
        CPU_RD
    } arb_state_t;

endpackage

// File: rtl/amstrad_wr_buffer.sv
// Single-entry posted-write buffer.
// A load takes priority over a clear; hit compares the held address against a CPU read.
module amstrad_wr_buffer
    import amstrad_ram_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              hit
);

    always_ff @(posedge CLK) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid && (addr == cmp_addr);

endmodule

// File: rtl/amstrad_ram_arbiter.sv
// Arbitrates gate-array video word fetches, posted CPU writes and CPU reads
// onto a single SDRAM request/ack channel.
module amstrad_ram_arbiter
    import amstrad_ram_arbiter_pkg::*;
#(
    parameter logic [6:0] VID_BASE = VID_BASE_DEFAULT,
    parameter logic [7:0] MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        err_timeout
);

    arb_state_t  state, state_next;
    logic        old_rd, old_wr, rd_edge, wr_edge;
    logic        rd_pending, rd_hit_pending, wr_stall, vid_pending;
    logic [22:0] rd_addr;
    logic [7:0]  hit_data, vid_lo_byte, wait_cnt;
    logic [14:0] vid_pend_addr;
    logic        buf_valid, buf_hit, buf_load, buf_clear;
    logic [22:0] buf_addr;
    logic [7:0]  buf_data;
    logic        grant_vid, grant_wr, grant_rd, acked, timed_out;

    assign rd_edge   = cpu_rd & ~old_rd;
    assign wr_edge   = cpu_wr & ~old_wr;
    assign buf_load  = ~buf_valid & (wr_stall | wr_edge);
    assign buf_clear = (state == CPU_WR) & (acked | timed_out);
    assign mem_req   = (state != IDLE);
    assign mem_we    = (state == CPU_WR);

    amstrad_wr_buffer u_wr_buffer (
        .CLK       (CLK),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_addr (cpu_addr),
        .load_data (cpu_dout),
        .cmp_addr  (cpu_addr),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .data      (buf_data),
        .hit       (buf_hit)
    );

    // Acks only count while an access is in flight, so a stray ack in IDLE is ignored.
    always_comb begin
        state_next = state;
        grant_vid  = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        if (state != IDLE) begin
            acked     = mem_ack;
            timed_out = ~mem_ack && (wait_cnt == MAX_WAIT - 8'd1);
        end
        unique case (state)
            IDLE: begin
                if (vid_pending) begin
                    grant_vid  = 1'b1;
                    state_next = VID_LO;
                end else if (buf_valid) begin
                    grant_wr   = 1'b1;
                    state_next = CPU_WR;
                end else if (rd_pending) begin
                    grant_rd   = 1'b1;
                    state_next = CPU_RD;
                end
            end
            VID_LO:                 if (acked) state_next = VID_HI;
            VID_HI, CPU_WR, CPU_RD: if (acked) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
        if (timed_out) state_next = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= IDLE;
            old_rd         <= 1'b0;
            old_wr         <= 1'b0;
            rd_pending     <= 1'b0;
            rd_hit_pending <= 1'b0;
            wr_stall       <= 1'b0;
            vid_pending    <= 1'b0;
            rd_addr        <= '0;
            hit_data       <= '0;
            vid_pend_addr  <= '0;
            vid_lo_byte    <= '0;
            wait_cnt       <= '0;
            cpu_din        <= OPEN_BUS;
            cpu_wait       <= 1'b0;
            vid_data       <= '0;
            vid_valid      <= 1'b0;
            err_timeout    <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            state       <= state_next;
            old_rd      <= cpu_rd;
            old_wr      <= cpu_wr;
            vid_valid   <= 1'b0;
            err_timeout <= timed_out;

            if (grant_vid | grant_wr | grant_rd | ((state == VID_LO) & acked))
                wait_cnt <= '0;
            else if (state != IDLE)
                wait_cnt <= wait_cnt + 8'd1;

            // A video request arriving while one is already pending is dropped.
            if (vid_req && !vid_pending) begin
                vid_pending   <= 1'b1;
                vid_pend_addr <= vid_addr;
            end
            if (grant_vid) begin
                vid_pending <= 1'b0;
                mem_addr    <= {VID_BASE, vid_pend_addr, 1'b0};
            end
            if (grant_wr) begin
                mem_addr  <= buf_addr;
                mem_wdata <= buf_data;
            end
            if (grant_rd) begin
                rd_pending <= 1'b0;
                mem_addr   <= rd_addr;
            end
            if ((state == VID_LO) && acked) begin
                vid_lo_byte <= mem_rdata;
                mem_addr[0] <= 1'b1;
            end
            if ((state == VID_HI) && acked) begin
                vid_data  <= {mem_rdata, vid_lo_byte};
                vid_valid <= 1'b1;
            end

            // Reads that hit the posted write are answered locally, one cycle after the wait.
            if (rd_edge) begin
                cpu_wait <= 1'b1;
                if (buf_hit) begin
                    rd_hit_pending <= 1'b1;
                    hit_data       <= buf_data;
                end else begin
                    rd_pending <= 1'b1;
                    rd_addr    <= cpu_addr;
                end
            end
            if (rd_hit_pending) begin
                rd_hit_pending <= 1'b0;
                cpu_din        <= hit_data;
                cpu_wait       <= 1'b0;
            end
            if ((state == CPU_RD) && acked) begin
                cpu_din  <= mem_rdata;
                cpu_wait <= 1'b0;
            end
            if ((state == CPU_RD) && timed_out) begin
                cpu_din  <= OPEN_BUS;
                cpu_wait <= 1'b0;
            end

            if (wr_edge && buf_valid) begin
                wr_stall <= 1'b1;
                cpu_wait <= 1'b1;
            end
            if (wr_stall && !buf_valid) begin
                wr_stall <= 1'b0;
                cpu_wait <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_amstrad_ram_arbiter.sv
// Directed self-checking bench for amstrad_ram_arbiter with a simple SDRAM responder.
// Read data from the responder is addr[7:0] ^ addr[15:8] ^ 8'hC3.
module tb_amstrad_ram_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr, vid_req, mem_ack;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_dout, cpu_din, mem_rdata, mem_wdata;
    logic        cpu_wait, vid_valid, mem_req, mem_we, err_timeout;
    logic [14:0] vid_addr;
    logic [15:0] vid_data;
    logic [22:0] mem_addr;

    amstrad_ram_arbiter dut (
        .CLK         (CLK),
        .reset       (reset),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .cpu_wait    (cpu_wait),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .err_timeout (err_timeout)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int ack_delay = 0;
    bit ack_enable = 1'b1;
    bit hold_odd = 1'b0;
    bit stray_ack = 1'b0;
    int resp_cnt = 0;
    int vid_valid_count = 0;
    int timeout_count = 0;
    logic [22:0] log_addr[$];
    logic        log_we[$];
    logic [7:0]  log_wdata[$];

    function automatic logic [7:0] mem_model(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    // SDRAM responder and pulse monitors, all working on the falling edge.
    always @(negedge CLK) begin
        if (vid_valid) vid_valid_count++;
        if (err_timeout) timeout_count++;
        if (mem_ack) begin
            mem_ack  = 1'b0;
            resp_cnt = 0;
        end else if ((mem_req || stray_ack) && ack_enable && !(hold_odd && mem_addr[0])) begin
            if (resp_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model(mem_addr);
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wdata.push_back(mem_wdata);
                resp_cnt  = 0;
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (mem_req && n < budget) begin
            tick(1);
            n++;
        end
        check_output(tag, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        int base, stall, req_cycles, n;
        int vv_base;
        bit found;

        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        reset     = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_dout  = '0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        tick(3);
        check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_cpu_din", {24'd0, cpu_din}, 32'hFF);
        check_output("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
        check_output("rst_vid_data", {16'd0, vid_data}, 32'd0);
        check_output("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
        reset = 1'b0;
        tick(2);
        check_output("idle_mem_req", {31'd0, mem_req}, 32'd0);

        $display("[TB] posted write then buffered read");
        ack_delay = 3;
        base = log_addr.size();
        cpu_addr = 23'h020100;
        cpu_dout = 8'h5A;
        cpu_wr = 1'b1;
        tick(1);
        check_output("wr_no_wait", {31'd0, cpu_wait}, 32'd0);
        tick(1);
        check_output("wr_mem_req", {31'd0, mem_req}, 32'd1);
        check_output("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check_output("wr_mem_addr", {9'd0, mem_addr}, 32'h020100);
        check_output("wr_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        tick(1);
        check_output("rdhit_wait", {31'd0, cpu_wait}, 32'd1);
        tick(1);
        check_output("rdhit_din", {24'd0, cpu_din}, 32'h5A);
        check_output("rdhit_release", {31'd0, cpu_wait}, 32'd0);
        cpu_rd = 1'b0;
        wait_idle("wr_drain_bound", 20);
        tick(5);
        check_output("wr_access_count", log_addr.size() - base, 32'd1);
        check_output("wr_log_addr", {9'd0, log_addr[base]}, 32'h020100);
        check_output("wr_log_we", {31'd0, log_we[base]}, 32'd1);
        check_output("wr_log_wdata", {24'd0, log_wdata[base]}, 32'h5A);
        check_output("wr_buf_empty", {31'd0, mem_req}, 32'd0);

        $display("[TB] video fetch alongside CPU read");
        ack_delay = 1;
        base = log_addr.size();
        vv_base = vid_valid_count;
        cpu_addr = 23'h012345;
        cpu_rd = 1'b1;
        vid_addr = 15'h0010;
        vid_req = 1'b1;
        tick(1);
        vid_req = 1'b0;
        check_output("vr_wait_set", {31'd0, cpu_wait}, 32'd1);
        n = 0;
        while (cpu_wait && n < 60) begin
            tick(1);
            n++;
        end
        check_output("vr_done_bound", {31'd0, cpu_wait}, 32'd0);
        tick(4);
        check_output("vr_access_count", log_addr.size() - base, 32'd3);
        check_output("vr_addr0", {9'd0, log_addr[base]}, 32'h020020);
        check_output("vr_addr1", {9'd0, log_addr[base + 1]}, 32'h020021);
        check_output("vr_addr2", {9'd0, log_addr[base + 2]}, 32'h012345);
        check_output("vr_vid_data", {16'd0, vid_data}, 32'hE2E3);
        check_output("vr_valid_pulses", vid_valid_count - vv_base, 32'd1);
        check_output("vr_cpu_din", {24'd0, cpu_din}, 32'hA5);
        cpu_rd = 1'b0;
        tick(2);

        $display("[TB] back-to-back writes with slow ack");
        ack_delay = 10;
        base = log_addr.size();
        cpu_addr = 23'h030000;
        cpu_dout = 8'h11;
        cpu_wr = 1'b1;
        tick(1);
        cpu_wr = 1'b0;
        tick(1);
        cpu_addr = 23'h030001;
        cpu_dout = 8'h22;
        cpu_wr = 1'b1;
        tick(1);
        check_output("wr2_stall", {31'd0, cpu_wait}, 32'd1);
        stall = 0;
        while (cpu_wait && stall < 40) begin
            tick(1);
            stall++;
        end
        check_output("wr2_stall_bound", {31'd0, cpu_wait}, 32'd0);
        check_output("wr2_stall_long", {31'd0, stall >= 10}, 32'd1);
        check_output("wr2_first_acked", log_addr.size() - base, 32'd1);
        cpu_wr = 1'b0;
        n = 0;
        while ((log_addr.size() - base < 2 || mem_req) && n < 40) begin
            tick(1);
            n++;
        end
        check_output("wr2_second_count", log_addr.size() - base, 32'd2);
        check_output("wr2_addr0", {9'd0, log_addr[base]}, 32'h030000);
        check_output("wr2_data0", {24'd0, log_wdata[base]}, 32'h11);
        check_output("wr2_addr1", {9'd0, log_addr[base + 1]}, 32'h030001);
        check_output("wr2_data1", {24'd0, log_wdata[base + 1]}, 32'h22);
        check_output("wr2_we1", {31'd0, log_we[base + 1]}, 32'd1);

        $display("[TB] read timeout");
        ack_enable = 1'b0;
        cpu_addr = 23'h010203;
        cpu_rd = 1'b1;
        req_cycles = 0;
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            tick(1);
            n++;
            if (mem_req) req_cycles++;
            if (err_timeout) found = 1'b1;
        end
        check_output("to_pulse_seen", {31'd0, found}, 32'd1);
        check_output("to_req_cycles", req_cycles, 32'd64);
        check_output("to_cpu_din", {24'd0, cpu_din}, 32'hFF);
        check_output("to_cpu_wait", {31'd0, cpu_wait}, 32'd0);
        check_output("to_mem_req", {31'd0, mem_req}, 32'd0);
        tick(1);
        check_output("to_pulse_width", {31'd0, err_timeout}, 32'd0);
        check_output("to_idle", {31'd0, mem_req}, 32'd0);
        cpu_rd = 1'b0;
        ack_enable = 1'b1;
        tick(2);

        $display("[TB] reset during second video byte");
        ack_delay = 0;
        hold_odd = 1'b1;
        base = log_addr.size();
        vv_base = vid_valid_count;
        vid_addr = 15'h7FFF;
        vid_req = 1'b1;
        tick(1);
        vid_req = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            if (mem_req && mem_addr == 23'h02FFFF) found = 1'b1;
            else begin
                tick(1);
                n++;
            end
        end
        check_output("rst_vid_hi_reached", {31'd0, found}, 32'd1);
        check_output("rst_vid_lo_addr", {9'd0, log_addr[base]}, 32'h02FFFE);
        reset = 1'b1;
        tick(1);
        check_output("rst_req_drop", {31'd0, mem_req}, 32'd0);
        reset = 1'b0;
        hold_odd = 1'b0;
        stray_ack = 1'b1;
        tick(1);
        stray_ack = 1'b0;
        tick(3);
        check_output("rst_stray_ack_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_no_vid_valid", vid_valid_count - vv_base, 32'd0);
        check_output("rst_vid_data_clr", {16'd0, vid_data}, 32'd0);
        check_output("rst_din_open_bus", {24'd0, cpu_din}, 32'hFF);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
